occupancy_map: RTL and testbench
================================

OCCUPANCY_MAP -- requirements
Module: occupancy_map

Interface
REQ-001 SHALL have parameter WIDTH, default 128: grid columns, 2..1024.
REQ-002 SHALL have parameter HEIGHT, default 32: grid rows, 2..1024.
REQ-003 SHALL have parameter WORD_SIZE, default 8: cell width in bits, 2..16.
REQ-004 SHALL have parameter INIT_VALUE, default 2**(WORD_SIZE-1): cell value after clear ("unknown").
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port clear_start, input, 1: one-cycle request to re-clear the map.
REQ-008 SHALL have port busy, output, 1: high while clearing.
REQ-009 SHALL have rd_valid (in, 1), rd_ready (out, 1), rd_x (in, $clog2(WIDTH)), rd_y (in, $clog2(HEIGHT)): read request.
REQ-010 SHALL have rd_data_valid (out, 1), rd_data (out, WORD_SIZE), rd_oob (out, 1): read response.
REQ-011 SHALL have upd_valid (in, 1), upd_ready (out, 1), upd_x, upd_y (in, as rd_x/rd_y), upd_delta (in, WORD_SIZE, signed two's complement): update request.

Function
REQ-012 Cell address SHALL be y*WIDTH + x; storage is one single-port synchronous RAM of WIDTH*HEIGHT words, one access per cycle.
REQ-013 Request transfer SHALL occur on a cycle with valid && ready; requests need not be held once transferred.
REQ-014 FSM states SHALL be CLEAR, IDLE, WRITE.
REQ-015 CLEAR: writes INIT_VALUE to address 0,1,...,N-1 (one per cycle, N=WIDTH*HEIGHT), then IDLE; busy=1, rd_ready=upd_ready=0 throughout.
REQ-016 IDLE: rd_ready=upd_ready=1; when both valid, read SHALL win and update waits.
REQ-017 Accepted read SHALL yield rd_data_valid=1 for exactly one cycle, the cycle after acceptance, with rd_data = cell value; reads sustain 1 per cycle; no response back-pressure.
REQ-018 Accepted update SHALL read the cell and go to WRITE; in WRITE, write sat(old + sext(delta)) clamped to [0, 2**WORD_SIZE-1], both readies 0, then IDLE: 1 update per 2 cycles.
REQ-019 Request after update to same cell SHALL observe the updated value (no forwarding needed: write precedes next acceptance).
REQ-020 Out-of-bounds (x>=WIDTH or y>=HEIGHT): read SHALL respond on schedule with rd_data=0, rd_oob=1, no RAM access; update SHALL be accepted and dropped, staying IDLE.
REQ-021 rd_oob SHALL be 0 on every in-bounds response and when rd_data_valid=0.
REQ-022 clear_start SHALL be honoured only in IDLE with no read accepted that cycle (clear_start takes priority over valids: readies drop same cycle combinationally); ignored in CLEAR and WRITE.
REQ-023 rd_data SHALL hold its last value when rd_data_valid=0.

Reset
REQ-024 On rst_n low: state=CLEAR, clear address=0, busy=1, rd_data_valid=0, rd_oob=0, rd_data=0, readies 0.
REQ-025 Reset asserted mid-clear or mid-WRITE SHALL abort the operation; clear restarts from address 0 after release; aborted write may be lost.
REQ-026 RAM contents SHALL not be reset; validity is guaranteed only by the post-reset clear.

Structure
REQ-027 Shared package map_pkg SHALL hold the state enum type and default constants (128, 32, 8); grid-index/word typedefs derived from parameters stay in-module.
REQ-028 Saturating add SHALL be sub-module sat_add (parameter WIDTH; unsigned a, signed b, clamped result).
REQ-029 RAM SHALL be an inferred array, no vendor primitive.

Verification (defaults unless noted)
REQ-030 Reset release -> busy=1 for exactly 4096 cycles, then readies 1; read (127,31) -> rd_data=128, rd_oob=0.
REQ-031 Update (5,3) delta +100, then delta +100 -> read (5,3) returns 255 (saturated); delta -128 x3 -> read returns 0.
REQ-032 Back-to-back reads (0,0),(1,0),(2,0) on consecutive cycles -> three consecutive rd_data_valid pulses, in order.
REQ-033 WIDTH=100, HEIGHT=20: read (110,5) -> rd_oob=1, rd_data=0; update (110,5) +1 -> no cell changes.
REQ-034 rd_valid and upd_valid together -> read accepted first, update next cycle; update then read same cell -> read sees new value.
REQ-035 clear_start after writes; reset pulsed at clear address 2000 -> full 4096-cycle clear after release, all cells 128.

Source files
------------

// File: rtl/map_pkg.sv
// Shared types and default geometry for the occupancy map.
package map_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } map_state_t;

  localparam int DEF_WIDTH     = 128;
  localparam int DEF_HEIGHT    = 32;
  localparam int DEF_WORD_SIZE = 8;

endpackage

// File: rtl/sat_add.sv
// Unsigned cell value plus signed delta, clamped to [0, 2**WIDTH-1].
module sat_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH+1:0] sum_s;

  // Two guard bits: top bit flags underflow, next bit flags overflow.
  always_comb begin
    sum_s = {2'b00, a} + {{2{b[WIDTH-1]}}, b};
    if (sum_s[WIDTH+1]) begin
      y = '0;
    end else if (sum_s[WIDTH]) begin
      y = '1;
    end else begin
      y = sum_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/occupancy_map.sv
// Occupancy grid held in one single-port RAM: clear sweep, reads, and
// saturating read-modify-write updates.
module occupancy_map
  import map_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int INIT_VALUE = 2**(WORD_SIZE-1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_start,
  output logic                       busy,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [$clog2(WIDTH)-1:0]   rd_x,
  input  logic [$clog2(HEIGHT)-1:0]  rd_y,
  output logic                       rd_data_valid,
  output logic [WORD_SIZE-1:0]       rd_data,
  output logic                       rd_oob,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [$clog2(WIDTH)-1:0]   upd_x,
  input  logic [$clog2(HEIGHT)-1:0]  upd_y,
  input  logic [WORD_SIZE-1:0]       upd_delta
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(N);

  typedef logic [AW-1:0]        addr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  word_t      mem [N];
  word_t      ram_q;
  map_state_t state_r;
  addr_t      clr_addr_r;
  addr_t      upd_addr_r;
  word_t      delta_r;
  logic       rd_data_valid_r;
  logic       rd_oob_r;
  word_t      rd_hold_r;

  logic  rd_fire_s, upd_fire_s, rd_inb_s, upd_inb_s;
  addr_t rd_addr_s, upd_addr_s;
  logic  ram_we_s, ram_re_s;
  addr_t ram_addr_s;
  word_t ram_wdata_s, sat_s;

  // clear_start pre-empts any request in the same cycle; a pending read
  // also holds off the update port.
  assign rd_ready   = (state_r == ST_IDLE) && !clear_start;
  assign upd_ready  = (state_r == ST_IDLE) && !clear_start && !rd_valid;
  assign rd_fire_s  = rd_valid && rd_ready;
  assign upd_fire_s = upd_valid && upd_ready;
  assign busy       = (state_r == ST_CLEAR);

  assign rd_inb_s   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign upd_inb_s  = (32'(upd_x) < WIDTH) && (32'(upd_y) < HEIGHT);
  assign rd_addr_s  = addr_t'(32'(rd_y) * WIDTH + 32'(rd_x));
  assign upd_addr_s = addr_t'(32'(upd_y) * WIDTH + 32'(upd_x));

  sat_add #(.WIDTH(WORD_SIZE)) u_sat_add (
    .a (ram_q),
    .b (delta_r),
    .y (sat_s)
  );

  // RAM port arbitration by FSM state.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_addr_s  = clr_addr_r;
    ram_wdata_s = word_t'(INIT_VALUE);
    case (state_r)
      ST_CLEAR: begin
        ram_we_s = 1'b1;
      end
      ST_IDLE: begin
        if (rd_fire_s && rd_inb_s) begin
          ram_re_s   = 1'b1;
          ram_addr_s = rd_addr_s;
        end else if (upd_fire_s && upd_inb_s) begin
          ram_re_s   = 1'b1;
          ram_addr_s = upd_addr_s;
        end else begin
          ram_re_s   = 1'b0;
        end
      end
      ST_WRITE: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = upd_addr_r;
        ram_wdata_s = sat_s;
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Inferred single-port RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem[ram_addr_s] <= ram_wdata_s;
    end else if (ram_re_s) begin
      ram_q <= mem[ram_addr_s];
    end
  end

  // Response data comes straight from the RAM output register on the
  // response cycle and is held from a shadow copy otherwise.
  always_comb begin
    if (!rd_data_valid_r) begin
      rd_data = rd_hold_r;
    end else if (rd_oob_r) begin
      rd_data = '0;
    end else begin
      rd_data = ram_q;
    end
  end

  assign rd_data_valid = rd_data_valid_r;
  assign rd_oob        = rd_oob_r;

  // Control FSM with registered response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_CLEAR;
      clr_addr_r      <= '0;
      upd_addr_r      <= '0;
      delta_r         <= '0;
      rd_data_valid_r <= 1'b0;
      rd_oob_r        <= 1'b0;
      rd_hold_r       <= '0;
    end else begin
      rd_data_valid_r <= 1'b0;
      rd_oob_r        <= 1'b0;
      if (rd_data_valid_r) begin
        rd_hold_r <= rd_data;
      end
      case (state_r)
        ST_CLEAR: begin
          if (clr_addr_r == addr_t'(N-1)) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= '0;
          end else begin
            clr_addr_r <= clr_addr_r + addr_t'(1);
          end
        end
        ST_IDLE: begin
          if (clear_start) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= '0;
          end else if (rd_fire_s) begin
            rd_data_valid_r <= 1'b1;
            rd_oob_r        <= !rd_inb_s;
          end else if (upd_fire_s && upd_inb_s) begin
            upd_addr_r <= upd_addr_s;
            delta_r    <= upd_delta;
            state_r    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_map.sv
// Scoreboard bench for occupancy_map: default 128x32 instance plus a
// 100x20 instance for out-of-bounds behaviour.
module tb_occupancy_map;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clear_start = 1'b0, busy;
  logic       rd_valid = 1'b0, rd_ready;
  logic [6:0] rd_x = 7'd0;
  logic [4:0] rd_y = 5'd0;
  logic       rd_data_valid, rd_oob;
  logic [7:0] rd_data;
  logic       upd_valid = 1'b0, upd_ready;
  logic [6:0] upd_x = 7'd0;
  logic [4:0] upd_y = 5'd0;
  logic [7:0] upd_delta = 8'd0;

  logic       s_clear_start = 1'b0, s_busy;
  logic       s_rd_valid = 1'b0, s_rd_ready;
  logic [6:0] s_rd_x = 7'd0;
  logic [4:0] s_rd_y = 5'd0;
  logic       s_rd_data_valid, s_rd_oob;
  logic [7:0] s_rd_data;
  logic       s_upd_valid = 1'b0, s_upd_ready;
  logic [6:0] s_upd_x = 7'd0;
  logic [4:0] s_upd_y = 5'd0;
  logic [7:0] s_upd_delta = 8'd0;

  occupancy_map dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_oob(rd_oob),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
    .upd_delta(upd_delta)
  );

  occupancy_map #(.WIDTH(100), .HEIGHT(20)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear_start(s_clear_start), .busy(s_busy),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_x(s_rd_x), .rd_y(s_rd_y),
    .rd_data_valid(s_rd_data_valid), .rd_data(s_rd_data), .rd_oob(s_rd_oob),
    .upd_valid(s_upd_valid), .upd_ready(s_upd_ready), .upd_x(s_upd_x), .upd_y(s_upd_y),
    .upd_delta(s_upd_delta)
  );

  int total = 0;
  int bad = 0;
  int model [4096];
  logic [8:0] sb [$];
  int vcyc [$];
  int cyc = 0;
  logic [7:0] last_data = 8'd0;
  logic [8:0] exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor for the default instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = 8'd0;
    end else if (rd_data_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got data=%0d oob=%0b, expected no response", rd_data, rd_oob);
      end else begin
        exp_v = sb.pop_front();
        if ({rd_oob, rd_data} !== exp_v) begin
          bad++;
          $display("FAIL rd_resp: got oob=%0b data=%0d, expected oob=%0b data=%0d",
                   rd_oob, rd_data, exp_v[8], exp_v[7:0]);
        end
      end
      last_data = rd_data;
      vcyc.push_back(cyc);
    end else begin
      total++;
      if (rd_oob !== 1'b0 || rd_data !== last_data) begin
        bad++;
        $display("FAIL idle_hold: got oob=%0b data=%0d, expected oob=0 data=%0d", rd_oob, rd_data, last_data);
      end
    end
  end

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic read_req(input int x, input int y);
    int n;
    bit oob;
    logic [7:0] e;
    oob = (x >= 128) || (y >= 32);
    e = oob ? 8'd0 : 8'(model[y*128 + x]);
    rd_valid = 1'b1;
    rd_x = 7'(x);
    rd_y = 5'(y);
    n = 0;
    @(negedge clk);
    while (!rd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rd_ready) begin
      total++;
      bad++;
      $display("FAIL rd_ready_timeout: got ready=0 after %0d cycles, expected 1", n);
      @(posedge clk); #1;
      rd_valid = 1'b0;
    end else begin
      sb.push_back({oob, e});
      @(posedge clk); #1;
      rd_valid = 1'b0;
    end
  endtask

  task automatic upd_req(input int x, input int y, input int d);
    int n;
    upd_valid = 1'b1;
    upd_x = 7'(x);
    upd_y = 5'(y);
    upd_delta = 8'(d);
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!upd_ready) begin
      total++;
      bad++;
      $display("FAIL upd_ready_timeout: got ready=0 after %0d cycles, expected 1", n);
    end else if (x < 128 && y < 32) begin
      model[y*128 + x] = clamp(model[y*128 + x] + d);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic count_busy(input int expn);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != expn) begin
      bad++;
      $display("FAIL busy_cycles: got %0d, expected %0d", n, expn);
    end
    total++;
    if (rd_ready !== 1'b1 || upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_clear: got rd=%0b upd=%0b, expected 1 1", rd_ready, upd_ready);
    end
    for (int i = 0; i < 4096; i++) model[i] = 128;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    total++;
    if ({busy, rd_ready, upd_ready, rd_data_valid, rd_oob} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got busy/rdr/updr/dv/oob=%b, expected 10000",
               {busy, rd_ready, upd_ready, rd_data_valid, rd_oob});
    end
    total++;
    if (rd_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_data: got %0d, expected 0", rd_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(4096);
    read_req(127, 31);
    read_req(0, 0);
  endtask

  task automatic test_saturate();
    upd_req(5, 3, 100);
    upd_req(5, 3, 100);
    read_req(5, 3);
    repeat (3) upd_req(5, 3, -128);
    read_req(5, 3);
  endtask

  task automatic test_back_to_back();
    upd_req(1, 0, 5);
    upd_req(2, 0, -7);
    repeat (2) @(posedge clk); #1;
    vcyc.delete();
    read_req(0, 0);
    read_req(1, 0);
    read_req(2, 0);
    @(posedge clk); #1;
    total++;
    if (vcyc.size() != 3 || vcyc[vcyc.size()-1] - vcyc[0] != 2) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d pulses, expected 3 consecutive", vcyc.size());
    end
  endtask

  task automatic test_priority();
    rd_valid = 1'b1; rd_x = 7'd4; rd_y = 5'd4;
    upd_valid = 1'b1; upd_x = 7'd4; upd_y = 5'd4; upd_delta = 8'd3;
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b1 || upd_ready !== 1'b0) begin
      bad++;
      $display("FAIL prio_first: got rd=%0b upd=%0b, expected 1 0", rd_ready, upd_ready);
    end
    sb.push_back({1'b0, 8'(model[4*128 + 4])});
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL prio_second: got upd_ready=%0b, expected 1", upd_ready);
    end
    model[4*128 + 4] = clamp(model[4*128 + 4] + 3);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    read_req(4, 4);
  endtask

  task automatic s_read(input int x, input int y, input logic [7:0] e, input logic oob);
    s_rd_valid = 1'b1; s_rd_x = 7'(x); s_rd_y = 5'(y);
    @(negedge clk);
    total++;
    if (s_rd_ready !== 1'b1) begin
      bad++;
      $display("FAIL s_rd_ready: got %0b, expected 1", s_rd_ready);
    end
    @(posedge clk); #1;
    s_rd_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({s_rd_data_valid, s_rd_oob, s_rd_data} !== {1'b1, oob, e}) begin
      bad++;
      $display("FAIL s_rd_resp (%0d,%0d): got v=%0b oob=%0b data=%0d, expected v=1 oob=%0b data=%0d",
               x, y, s_rd_data_valid, s_rd_oob, s_rd_data, oob, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic s_upd(input int x, input int y, input int d, input logic ready_after);
    s_upd_valid = 1'b1; s_upd_x = 7'(x); s_upd_y = 5'(y); s_upd_delta = 8'(d);
    @(negedge clk);
    total++;
    if (s_upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL s_upd_ready: got %0b, expected 1", s_upd_ready);
    end
    @(posedge clk); #1;
    s_upd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s_upd_ready !== ready_after) begin
      bad++;
      $display("FAIL s_upd_after (%0d,%0d): got ready=%0b, expected %0b", x, y, s_upd_ready, ready_after);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_oob();
    int n;
    n = 0;
    while (s_busy === 1'b1 && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (s_busy !== 1'b0) begin
      bad++;
      $display("FAIL s_busy_timeout: got busy=%0b, expected 0", s_busy);
    end
    s_read(110, 5, 8'd0, 1'b1);
    s_read(99, 19, 8'd128, 1'b0);
    s_upd(110, 5, 1, 1'b1);
    s_read(10, 6, 8'd128, 1'b0);
    s_read(10, 5, 8'd128, 1'b0);
    s_upd(10, 5, 1, 1'b0);
    s_read(10, 5, 8'd129, 1'b0);
  endtask

  task automatic test_clear_reset();
    upd_req(9, 9, 50);
    read_req(9, 9);
    clear_start = 1'b1;
    rd_valid = 1'b1; rd_x = 7'd9; rd_y = 5'd9;
    @(negedge clk);
    total++;
    if (rd_ready !== 1'b0 || upd_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_prio: got rd=%0b upd=%0b, expected 0 0", rd_ready, upd_ready);
    end
    @(posedge clk); #1;
    clear_start = 1'b0;
    rd_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clear_busy: got %0b, expected 1", busy);
    end
    repeat (2000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(4096);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 128; x++) begin
        read_req(x, y);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) model[i] = 128;
    test_reset();
    test_saturate();
    test_back_to_back();
    test_priority();
    test_oob();
    test_clear_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_resp: got %0d outstanding, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
